// File: rtl/pc_pkg.sv
// -----------------------------------------------------------------------------
// pc_pkg
// Shared types for the program-counter fetch sequencer.
//   PC_W        : program counter / branch offset width
//   pc_state_e  : sequencer states
//   pc_ctrl_t   : 19-bit PC control word {inc, add, sub, offset}, in the bit
//                 order the PC register consumes it
// -----------------------------------------------------------------------------
package pc_pkg;

   localparam int PC_W = 16;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH   = 3'd1,
      ADVANCE = 3'd2,
      HALTED  = 3'd3,
      ERROR   = 3'd4
   } pc_state_e;

   typedef struct packed {
      logic            inc;
      logic            add;
      logic            sub;
      logic [PC_W-1:0] offset;
   } pc_ctrl_t;

endpackage

// File: rtl/br_slot.sv
// -----------------------------------------------------------------------------
// br_slot
// Single-entry capture register for branch requests from decode.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   enable            : slot may accept a request this cycle
//   clr               : drop the held request (it has been consumed)
//   br_valid/br_ready : valid/ready handshake with decode
//   br_neg, br_offset : request payload (direction, magnitude)
//   full, neg, off    : held request state
// -----------------------------------------------------------------------------
module br_slot
   import pc_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            enable,
   input  logic            clr,
   input  logic            br_valid,
   input  logic            br_neg,
   input  logic [PC_W-1:0] br_offset,
   output logic            br_ready,
   output logic            full,
   output logic            neg,
   output logic [PC_W-1:0] off
);

   logic            full_q, full_d;
   logic            neg_q,  neg_d;
   logic [PC_W-1:0] off_q,  off_d;
   logic            push;

   assign br_ready = enable && !full_q;
   assign push     = br_valid && br_ready;

   // Capture needs an empty slot and clear needs a full one, so the two never
   // collide; a request accepted while an update consumes nothing waits for
   // the next update.
   always_comb begin
      // NOTE: every _d gets its default before any branch so no path infers a latch.
      full_d = full_q;
      neg_d  = neg_q;
      off_d  = off_q;
      if (push) begin
         full_d = 1'b1;
         neg_d  = br_neg;
         off_d  = br_offset;
      end else if (clr) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: state uses non-blocking assignments; the payload is reset too so
      // nothing stale can ever reach the offset output.
      if (!reset) begin
         full_q <= 1'b0;
         neg_q  <= 1'b0;
         off_q  <= '0;
      end else begin
         full_q <= full_d;
         neg_q  <= neg_d;
         off_q  <= off_d;
      end
   end

   assign full = full_q;
   assign neg  = neg_q;
   assign off  = off_q;

endmodule

// File: rtl/pc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pc_seq_ctrl
// Fetch sequencer: requests an instruction, then issues exactly one PC update
// (or none, for a zero-offset branch) per fetched instruction.
// The update decision is made in the ADVANCE cycle (stall, halt and the branch
// slot sampled there) and the one-hot control word is registered, so the
// inc/add/sub pulse is visible during the following cycle and the PC moves on
// the edge that ends it.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   start, halt, stall  : run control levels
//   imem_req, imem_ack  : instruction memory handshake
//   br_valid, br_ready  : branch request handshake; br_neg, br_offset payload
//   inc, add, sub       : one-hot PC update controls (registered)
//   offset              : branch offset while add/sub is high, else 0
//   busy                : in FETCH or ADVANCE
//   err                 : fetch timeout (sticky until reset)
//   fetch_cnt           : completed fetches, saturating
// -----------------------------------------------------------------------------
module pc_seq_ctrl
   import pc_pkg::*;
#(
   parameter int TIMEOUT = 8,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             halt,
   input  logic             stall,
   output logic             imem_req,
   input  logic             imem_ack,
   input  logic             br_valid,
   input  logic             br_neg,
   input  logic [PC_W-1:0]  br_offset,
   output logic             br_ready,
   output logic             inc,
   output logic             add,
   output logic             sub,
   output logic [PC_W-1:0]  offset,
   output logic             busy,
   output logic             err,
   output logic [CNT_W-1:0] fetch_cnt
);

   localparam int               TMO_W    = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   pc_state_e        state_q, state_d;
   pc_ctrl_t         ctrl_q,  ctrl_d;
   logic [TMO_W-1:0] tmo_q,   tmo_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   logic             slot_clr;
   logic             slot_full;
   logic             slot_neg;
   logic [PC_W-1:0]  slot_off;

   assign busy     = (state_q == FETCH) || (state_q == ADVANCE);
   assign imem_req = (state_q == FETCH);
   assign err      = (state_q == ERROR);

   br_slot u_br_slot (
      .clk       (clk),
      .reset     (reset),
      .enable    (busy),
      .clr       (slot_clr),
      .br_valid  (br_valid),
      .br_neg    (br_neg),
      .br_offset (br_offset),
      .br_ready  (br_ready),
      .full      (slot_full),
      .neg       (slot_neg),
      .off       (slot_off)
   );

   always_comb begin
      state_d  = state_q;
      ctrl_d   = '0;
      tmo_d    = '0;
      cnt_d    = cnt_q;
      slot_clr = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && !halt) state_d = FETCH;
         end

         FETCH: begin
            // An ack on the last allowed cycle still counts as a fetch.
            if (imem_ack) begin
               state_d = ADVANCE;
               if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
            end else if (tmo_q == TMO_LAST) begin
               state_d = ERROR;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         ADVANCE: begin
            if (!stall) begin
               if (slot_full) begin
                  slot_clr = 1'b1;
                  // A zero-magnitude branch is a self-loop: consume it, move nothing.
                  if (slot_off != '0) begin
                     ctrl_d.add    = !slot_neg;
                     ctrl_d.sub    = slot_neg;
                     ctrl_d.offset = slot_off;
                  end
               end else begin
                  ctrl_d.inc = 1'b1;
               end
               state_d = halt ? HALTED : FETCH;
            end
         end

         HALTED: begin
            if (start && !halt) state_d = FETCH;
         end

         ERROR: begin
            state_d = ERROR;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         ctrl_q  <= '0;
         tmo_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         tmo_q   <= tmo_d;
         cnt_q   <= cnt_d;
      end
   end

   assign inc       = ctrl_q.inc;
   assign add       = ctrl_q.add;
   assign sub       = ctrl_q.sub;
   assign offset    = ctrl_q.offset;
   assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_seq_ctrl
// Bench for pc_seq_ctrl. A behavioural PC register follows the DUT controls;
// expected update words are queued when an update cycle is driven and are
// popped by a monitor whenever a control pulse appears.
// -----------------------------------------------------------------------------
module tb_pc_seq_ctrl;
   import pc_pkg::*;

   localparam int TIMEOUT = 8;
   localparam int CNT_W   = 16;

   localparam pc_ctrl_t INC = '{inc: 1'b1, add: 1'b0, sub: 1'b0, offset: 16'h0000};

   logic             clk = 1'b0;
   logic             reset;
   logic             start, halt, stall;
   logic             imem_req, imem_ack;
   logic             br_valid, br_neg, br_ready;
   logic [PC_W-1:0]  br_offset;
   logic             inc, add, sub;
   logic [PC_W-1:0]  offset;
   logic             busy, err;
   logic [CNT_W-1:0] fetch_cnt;

   logic [PC_W-1:0]  pc = '0;

   int vectors     = 0;
   int miscompares = 0;

   pc_ctrl_t sb_q[$];
   pc_ctrl_t mon_act, mon_exp;

   typedef struct {
      int          ack_delay;
      bit          br_fetch;
      bit          dup;
      bit          br_adv;
      bit          br_neg;
      logic [15:0] br_off;
      int          stall_n;
      bit          halt;
      bit          e_inc;
      bit          e_add;
      bit          e_sub;
      logic [15:0] e_off;
      logic [15:0] exp_pc;
      logic [15:0] exp_cnt;
   } txn_t;

   txn_t tbl[13];

   pc_seq_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .halt      (halt),
      .stall     (stall),
      .imem_req  (imem_req),
      .imem_ack  (imem_ack),
      .br_valid  (br_valid),
      .br_neg    (br_neg),
      .br_offset (br_offset),
      .br_ready  (br_ready),
      .inc       (inc),
      .add       (add),
      .sub       (sub),
      .offset    (offset),
      .busy      (busy),
      .err       (err),
      .fetch_cnt (fetch_cnt)
   );

   always #5 clk = ~clk;

   // The PC register this block controls.
   always @(posedge clk) begin
      if (inc)      pc <= pc + 16'd1;
      else if (add) pc <= pc + offset;
      else if (sub) pc <= pc - offset;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Any pulse must match the next queued update; between pulses offset is 0.
   always @(negedge clk) begin
      mon_act = {inc, add, sub, offset};
      if (inc || add || sub) begin
         if (sb_q.size() == 0) begin
            check("unexpected_pulse", {29'd0, inc, add, sub}, 32'd0);
         end else begin
            mon_exp = sb_q.pop_front();
            check("pulse", 32'(mon_act), 32'(mon_exp));
         end
      end else begin
         check("idle_offset", 32'(offset), 32'd0);
      end
   end

   function automatic txn_t mk(int d, bit bf, bit dup, bit ba, bit bn, logic [15:0] bo,
                               int st, bit h, bit ei, bit ea, bit es, logic [15:0] eo,
                               logic [15:0] epc, logic [15:0] ecnt);
      txn_t t;
      t.ack_delay = d;  t.br_fetch = bf; t.dup = dup;   t.br_adv = ba;
      t.br_neg    = bn; t.br_off   = bo; t.stall_n = st; t.halt  = h;
      t.e_inc     = ei; t.e_add    = ea; t.e_sub   = es; t.e_off = eo;
      t.exp_pc    = epc; t.exp_cnt = ecnt;
      return t;
   endfunction

   task automatic run_txn(input int idx, input txn_t v);
      int       n;
      pc_ctrl_t e;
      n = 0;
      while (!imem_req && n < 20) begin
         tick();
         n++;
      end
      check($sformatf("t%0d_fetch_entry", idx), imem_req, 1);
      if (v.br_fetch) begin
         check($sformatf("t%0d_br_ready_fetch", idx), br_ready, 1);
         br_valid = 1'b1; br_neg = v.br_neg; br_offset = v.br_off;
         tick();
         br_valid = 1'b0;
         if (v.dup) begin
            br_valid = 1'b1; br_neg = 1'b0; br_offset = 16'h0777;
            check($sformatf("t%0d_br_ready_full", idx), br_ready, 0);
            tick();
            br_valid = 1'b0;
         end
      end
      repeat (v.ack_delay) tick();
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      check($sformatf("t%0d_in_advance", idx), {busy, imem_req}, 2'b10);
      repeat (v.stall_n) begin
         stall = 1'b1;
         tick();
      end
      stall = 1'b0;
      if (v.stall_n > 0) check($sformatf("t%0d_stall_hold", idx), {busy, imem_req}, 2'b10);
      if (v.br_adv) begin
         check($sformatf("t%0d_br_ready_adv", idx), br_ready, 1);
         br_valid = 1'b1; br_neg = v.br_neg; br_offset = v.br_off;
      end
      halt = v.halt;
      if (v.e_inc || v.e_add || v.e_sub) begin
         e = '{inc: v.e_inc, add: v.e_add, sub: v.e_sub, offset: v.e_off};
         sb_q.push_back(e);
      end
      tick();
      br_valid = 1'b0;
      tick();
      check($sformatf("t%0d_pc", idx), 32'(pc), 32'(v.exp_pc));
      check($sformatf("t%0d_fetch_cnt", idx), 32'(fetch_cnt), 32'(v.exp_cnt));
      if (v.halt) begin
         check($sformatf("t%0d_halted", idx), {busy, imem_req, br_ready, inc, add, sub}, 6'b0);
         start = 1'b1;
         repeat (2) tick();
         check($sformatf("t%0d_halt_wins", idx), busy, 0);
         halt = 1'b0;
         tick();
         start = 1'b0;
         check($sformatf("t%0d_resume", idx), imem_req, 1);
      end
   endtask

   // Asserts reset between clock edges: outputs must clear before any edge.
   task automatic async_reset(input string name);
      #2 reset = 1'b0;
      #1;
      check({name, "_clear"}, {imem_req, busy, br_ready, err, inc, add, sub}, 7'b0);
      check({name, "_cnt"}, 32'(fetch_cnt), 32'd0);
      tick();
      reset = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;

      tbl[0]  = mk(1, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h0001, 16'd1);
      tbl[1]  = mk(1, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h0002, 16'd2);
      tbl[2]  = mk(1, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h0003, 16'd3);
      tbl[3]  = mk(1, 1, 0, 0, 0, 16'h00a5, 0, 0, 0, 1, 0, 16'h00a5, 16'h00a8, 16'd4);
      tbl[4]  = mk(1, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h00a9, 16'd5);
      tbl[5]  = mk(1, 1, 1, 0, 1, 16'h0014, 0, 0, 0, 0, 1, 16'h0014, 16'h0095, 16'd6);
      tbl[6]  = mk(1, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h0096, 16'd7);
      tbl[7]  = mk(1, 0, 0, 0, 0, 16'h0000, 3, 0, 1, 0, 0, 16'h0000, 16'h0097, 16'd8);
      tbl[8]  = mk(1, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 0, 0, 16'h0000, 16'h0098, 16'd9);
      tbl[9]  = mk(1, 0, 0, 1, 0, 16'h0100, 0, 0, 1, 0, 0, 16'h0000, 16'h0099, 16'd10);
      tbl[10] = mk(1, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 1, 0, 16'h0100, 16'h0199, 16'd11);
      tbl[11] = mk(1, 1, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0199, 16'd12);
      tbl[12] = mk(1, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h019a, 16'd13);

      reset = 1'b0; start = 1'b0; halt = 1'b0; stall = 1'b0;
      imem_ack = 1'b0; br_valid = 1'b0; br_neg = 1'b0; br_offset = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", {imem_req, busy, err, br_ready, inc, add, sub}, 7'b0);
      check("reset_offset", 32'(offset), 32'd0);
      check("reset_cnt", 32'(fetch_cnt), 32'd0);
      reset = 1'b1;
      tick();
      tick();
      check("idle_hold", {busy, imem_req, br_ready}, 3'b000);

      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 13; i++) run_txn(i, tbl[i]);
      check("table_sb_empty", sb_q.size(), 0);

      // Ack arriving on the final allowed FETCH cycle wins over the timeout.
      async_reset("rst_a");
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (TIMEOUT - 1) tick();
      check("last_count_fetch", {err, imem_req}, 2'b01);
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      check("last_count_ack", {err, busy, imem_req}, 3'b010);
      sb_q.push_back(INC);
      tick();
      tick();
      check("last_count_pc", 32'(pc), 32'h019b);
      check("last_count_cnt", 32'(fetch_cnt), 32'd1);

      // No ack: ERROR after TIMEOUT FETCH cycles, sticky until reset.
      async_reset("rst_b");
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (imem_req && n < 20) begin
         tick();
         n++;
      end
      check("timeout_cycles", n, TIMEOUT);
      check("err_state", {err, imem_req, busy, br_ready, inc, add, sub}, 7'b1000000);
      start = 1'b1; imem_ack = 1'b1; br_valid = 1'b1;
      repeat (3) tick();
      start = 1'b0; imem_ack = 1'b0; br_valid = 1'b0;
      check("err_sticky", {err, busy}, 2'b10);
      async_reset("rst_c");

      // Reset mid-FETCH with a branch held: the branch must be discarded.
      start = 1'b1;
      tick();
      start = 1'b0;
      br_valid = 1'b1; br_neg = 1'b0; br_offset = 16'h0010;
      tick();
      br_valid = 1'b0;
      check("pending_held", br_ready, 0);
      async_reset("rst_d");
      start = 1'b1;
      tick();
      start = 1'b0;
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      sb_q.push_back(INC);
      tick();
      tick();
      check("discard_pc", 32'(pc), 32'h019c);
      check("final_sb_empty", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Fetch sequencer that drives the 16-bit program counter's one-hot update controls (`inc`, `add`, `sub`, `offset`).
- Handshakes with instruction memory and accepts branch requests from decode over a valid/ready interface.
- Guarantees that exactly one PC update (or none) occurs per fetched instruction.
- Sits between the PC register, instruction memory port and decode stage.

Parameters:
- TIMEOUT, 8, max cycles FETCH waits for `imem_ack` before entering ERROR (≥1)
- CNT_W, 16, width of retired-fetch counter

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE and begin fetching (level, sampled in IDLE)
- halt  in  1  stop after current update (level)
- stall  in  1  hold in ADVANCE, no PC update this cycle
- imem_req  out  1  fetch request to instruction memory
- imem_ack  in  1  fetch complete, instruction valid this cycle
- br_valid  in  1  branch request valid
- br_neg  in  1  1 = backward branch (sub), 0 = forward (add)
- br_offset  in  16  branch magnitude
- br_ready  out  1  branch slot free
- inc  out  1  PC += 1 on next edge
- add  out  1  PC += offset on next edge
- sub  out  1  PC -= offset on next edge
- offset  out  16  offset to PC
- busy  out  1  state is FETCH or ADVANCE
- err  out  1  fetch timeout, sticky
- fetch_cnt  out  CNT_W  completed fetches, saturating

Behaviour:
- Reset (`reset`=0, async):
  - state=IDLE, branch slot empty.
  - `inc`/`add`/`sub`/`imem_req`/`busy`/`err`=0, `offset`=0, `fetch_cnt`=0, timeout counter=0.
- Output encoding:
  - `inc`/`add`/`sub` are registered (state-decoded from registered state) and at most one is high in any cycle.
  - `offset` holds the captured branch offset while `add`/`sub`=1, else 0.
- IDLE:
  - `br_ready`=0.
  - `start`=1 -> FETCH.
- FETCH:
  - `imem_req`=1; timeout counter increments each cycle without ack.
  - `imem_ack`=1 -> ADVANCE, `fetch_cnt`+1 (saturates at all-ones), counter cleared.
  - Counter reaches TIMEOUT-1 with no ack -> ERROR.
  - Ack on the same cycle as that final count wins (-> ADVANCE).
- ADVANCE, one update cycle unless stalled:
  - `stall`=1: no control pulse, stay in ADVANCE.
  - Otherwise, with branch pending:
    - `br_neg`=0 -> `add`=1; `br_neg`=1 -> `sub`=1; `offset`=captured value.
    - Slot cleared.
    - Captured offset 0 -> no pulse (PC holds, self-loop); slot still cleared.
  - Otherwise, no branch pending: `inc`=1.
  - Then `halt`=1 -> HALTED, else -> FETCH.
- HALTED:
  - All controls 0; `br_ready`=0.
  - `halt`=0 and `start`=1 -> FETCH.
- ERROR:
  - `err`=1, all controls 0, `br_ready`=0.
  - Exit only via reset.
- Branch slot:
  - `br_ready` = slot empty and state ∈ {FETCH, ADVANCE}.
  - Capture on `br_valid`&&`br_ready`.
  - A request captured in the same cycle as an ADVANCE update applies to the next update, not the current one.
- PC arithmetic wraps modulo 2^16; wrapping is the PC's job, not this block's.
- `halt` and `start` both high: `halt` wins.
- Reset mid-FETCH: `imem_req` drops immediately (async), pending branch discarded.

Decomposition:
- Shared package `pc_pkg`:
  - state enum: IDLE, FETCH, ADVANCE, HALTED, ERROR
  - PC_W=16
  - control-vector typedef {`inc`, `add`, `sub`, `offset`} matching the PC's 19-bit control word order
- Natural sub-module `br_slot`: single-entry valid/ready capture register holding {`br_neg`, `br_offset`}, with a clear input.
- FSM, timeout counter and fetch counter live in `pc_seq_ctrl`.

Test Plan:
- Reset release then `start`=1, memory acks every 2nd cycle, no branches for 3 fetches -> three single-cycle `inc` pulses; PC 0000->0003; `fetch_cnt`=3.
- Forward branch: `br_valid` with `br_neg`=0, `br_offset`=00a5 during FETCH at PC=0003 -> next ADVANCE drives `add`=1, `offset`=00a5; PC=00a8; following update is `inc` (00a9).
- Backward branch: `br_neg`=1, `br_offset`=0014 at PC=00a9 -> `sub`=1; PC=0095. A second `br_valid` while the slot is full sees `br_ready`=0 and is not captured.
- `stall`=1 for 3 cycles in ADVANCE -> no control pulses, PC unchanged. Release -> one `inc`; `halt`=1 in ADVANCE -> HALTED with all controls 0. Then `start` (halt low) -> FETCH resumes.
- TIMEOUT=8, `imem_ack` held 0 -> ERROR after 8 FETCH cycles; `err`=1, `imem_req`=0, sticky. Async `reset` low mid-state clears everything to reset values within the same cycle.
- Zero-offset branch (`br_offset`=0000) -> ADVANCE cycle with `inc`=`add`=`sub`=0; PC held; slot cleared; next update is `inc`.
